alu_arbiter: RTL

Round-robin arbiter that shares one combinational ALU (32-bit, 3-bit ALUControl, Zero/Sign flags) between two requesters: the core execute path and a secondary unit such as an address generator or an iterative multiply/divide sequencer. It grants one operation per cycle with a valid/ready handshake and drives the ALU operands. It registers the ALU result and flags and returns them one cycle later, tagged by requester. A lock mechanism lets a requester hold the ALU for back-to-back dependent operations.

---
 rtl/alu_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Zero-latency grant, one-cycle registered response, optional grant lock.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Stall,
    input  logic         ReqValid0,
    input  logic         ReqValid1,
    output logic         ReqReady0,
    output logic         ReqReady1,
    input  logic [N-1:0] ReqA0,
    input  logic [N-1:0] ReqA1,
    input  logic [N-1:0] ReqB0,
    input  logic [N-1:0] ReqB1,
    input  logic [2:0]   ReqCtrl0,
    input  logic [2:0]   ReqCtrl1,
    input  logic         ReqLock0,
    input  logic         ReqLock1,
    output logic [N-1:0] SrcA,
    output logic [N-1:0] SrcB,
    output logic [2:0]   ALUControl,
    input  logic [N-1:0] ALUResult,
    input  logic         Zero,
    input  logic         Sign,
    output logic         RspValid0,
    output logic         RspValid1,
    output logic [N-1:0] RspResult,
    output logic         RspZero,
    output logic         RspSign
);

    logic last_grant;
    logic locked;
    logic lock_owner;
    logic g0;
    logic g1;
    logic hs0;
    logic hs1;
    logic hs_lock;

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!Stall) begin
            if (locked) begin
                // the non-owner is starved even while the owner is idle
                g0 = !lock_owner && ReqValid0;
                g1 = lock_owner && ReqValid1;
            end else if (ReqValid0 && ReqValid1) begin
                g0 = last_grant;
                g1 = !last_grant;
            end else begin
                g0 = ReqValid0;
                g1 = ReqValid1;
            end
        end
    end

    assign ReqReady0 = g0;
    assign ReqReady1 = g1;
    assign hs0 = ReqValid0 && g0;
    assign hs1 = ReqValid1 && g1;
    assign hs_lock = hs0 ? ReqLock0 : ReqLock1;

    always_comb begin
        SrcA       = '0;
        SrcB       = '0;
        ALUControl = 3'b000;
        if (g0) begin
            SrcA       = ReqA0;
            SrcB       = ReqB0;
            ALUControl = ReqCtrl0;
        end else if (g1) begin
            SrcA       = ReqA1;
            SrcB       = ReqB1;
            ALUControl = ReqCtrl1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            locked     <= 1'b0;
            lock_owner <= 1'b0;
            RspValid0  <= 1'b0;
            RspValid1  <= 1'b0;
            RspResult  <= '0;
            RspZero    <= 1'b0;
            RspSign    <= 1'b0;
        end else begin
            RspValid0 <= hs0;
            RspValid1 <= hs1;
            if (hs0 || hs1) begin
                last_grant <= hs1;
                RspResult  <= ALUResult;
                RspZero    <= Zero;
                RspSign    <= Sign;
                // only the owner can handshake while locked
                locked     <= hs_lock;
                if (hs_lock) lock_owner <= hs1;
            end
        end
    end

endmodule
